// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } nsa_state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic nsa_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// Existing 4-bit carry-lookahead slice with group propagate/generate outputs.
module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] R,
    output logic       Cout,
    output logic       PG,
    output logic       GG
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    always_comb begin
        p    = A ^ B;
        g    = A & B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
        GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        PG   = &p;
        Cout = GG | (PG & Cin);
        R    = p ^ c;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one CLA_4bit slice iterated LSB-first, one nibble per cycle.
// Define SUB_EN to add a 'sub' input that computes a - b instead of a + b + cin.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(NIB + 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    nsa_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;

    logic [3:0] slice_r;
    logic       slice_cout;
    logic       pg_unused;
    logic       gg_unused;

    CLA_4bit u_cla (
        .A    (op_a_q[3:0]),
        .B    (op_b_q[3:0]),
        .Cin  (carry_q),
        .R    (slice_r),
        .Cout (slice_cout),
        .PG   (pg_unused),
        .GG   (gg_unused)
    );

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_a_d = a;
`ifdef SUB_EN
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    op_b_d  = b;
                    carry_d = cin;
`endif
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = op_b_d[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Slice result enters at the top so the first nibble ends up in bits [3:0].
                acc_d   = WIDTH'({slice_r, acc_q} >> 4);
                op_a_d  = op_a_q >> 4;
                op_b_d  = op_b_q >> 4;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NIB - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = slice_cout;
                    ovf_d   = nsa_ovf(a_msb_q, b_msb_q, slice_r[3]);
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16) with an expected-result queue.
module tb_nibble_serial_adder_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
    } op_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    // Reference: plain integer add, overflow from the signed range.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                   input logic tc, input logic ts);
        exp_t         e;
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   full;
        int           sa;
        int           sbv;
        int           t;
        bb   = ts ? ~tb_v : tb_v;
        cc   = ts ? 1'b1 : tc;
        full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, cc};
        sa   = $signed(ta);
        sbv  = $signed(bb);
        t    = sa + sbv + int'(cc);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (t > 32767) || (t < -32768);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input bit push);
        bit ok;
        ok       = 1'b0;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        if (push) sb.push_back(model(ta, tb_v, tc, ts));
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        acc_cyc = cyc;
        check("accept_seen", 32'(ok), 32'd1);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
    endtask

    task automatic receive(input string tag);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_valid_seen"}, 32'(ok), 32'd1);
        check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(NIB));
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_sum"}, 32'(sum), 32'(e.sum));
        check({tag, "_cout"}, 32'(cout), 32'(e.cout));
        check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_valid_width"}, 32'(out_valid), 32'd0);
            check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    op_t ops [7];

    initial begin
        ops[0] = '{a: 16'h1234, b: 16'h0F0F, c: 1'b0, s: 1'b0};
        ops[1] = '{a: 16'hFFFF, b: 16'h0001, c: 1'b0, s: 1'b0};
        ops[2] = '{a: 16'h0000, b: 16'h0000, c: 1'b1, s: 1'b0};
        ops[3] = '{a: 16'h7FFF, b: 16'h0001, c: 1'b0, s: 1'b0};
        ops[4] = '{a: 16'h8000, b: 16'h8000, c: 1'b0, s: 1'b0};
        ops[5] = '{a: 16'h0FFF, b: 16'h0001, c: 1'b1, s: 1'b0};
        ops[6] = '{a: 16'hF0F0, b: 16'h8F0F, c: 1'b1, s: 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (ops[i]) begin
            send(ops[i].a, ops[i].b, ops[i].c, ops[i].s, 1'b1);
            receive($sformatf("op%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            receive($sformatf("rnd%0d", i));
        end

        // Backpressure: result held while a new operand waits at the input.
        out_ready = 1'b0;
        send(16'h5555, 16'h1234, 1'b0, 1'b0, 1'b1);
        receive("bp");
        a        = 16'hAAAA;
        b        = 16'h0101;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        sb.push_back(model(16'hAAAA, 16'h0101, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold_sum%0d", i), 32'(sum), 32'h6789);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_sum", 32'(sum), 32'h6789);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        receive("bp_next");

        // Reset in the middle of an operation discards it.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
        receive("after_rst");

`ifdef SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        receive("sub0");
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
        receive("sub1");
        send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
        receive("sub2");
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that computes a WIDTH-bit add using one 4-bit CLA slice (CLA_4bit), iterated over WIDTH/4 cycles.
- Takes operands with a valid/ready handshake.
- Feeds one nibble per cycle LSB-first, chaining carry through a register.
- Presents the result on a valid/ready output.
- Serves as the area-reduced adder path for multi-cycle ALU ops in the pipelined CPU.

Parameters:
- WIDTH, 16: operand width in bits; must be a multiple of 4 and ≥4 (elaboration error otherwise).
- NIB, WIDTH/4: derived, localparam; number of nibble cycles.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  controller can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, nibble counter=0, carry reg=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b and cin; latch a[WIDTH-1] and b[WIDTH-1] for ovf; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, CLA slice inputs are A=opA[3:0], B=opB[3:0], Cin=carry reg.
  - At the edge: shift opA/opB right by 4; shift the slice R into sum[WIDTH-1:WIDTH-4] with sum shifting right by 4; carry reg <= slice Cout; counter++.
  - After NIB RUN cycles go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable; cout = final carry reg.
  - ovf = (a_msb==b_msb) && (sum[WIDTH-1]!=a_msb).
  - On out_valid&&out_ready go to IDLE. Outputs keep their values until the next result overwrites them.
- Latency: out_valid rises exactly NIB cycles after the accept edge (4 for WIDTH=16). Throughput is one op per NIB+2 cycles minimum.
- in_ready is high only in IDLE. in_valid seen in RUN or DONE is ignored, and operands are not sampled.
- out_ready outside DONE has no effect.
- Inputs a, b and cin may change freely after acceptance; only latched copies are used.
- Reset mid-RUN or mid-DONE:
  - Immediate return to reset values; the in-flight op is discarded.
  - The first accept after deassertion behaves normally.
- Wrap-around: carry out of the final nibble goes to cout only; it is never fed back.

Optional Feature:
- SUB_EN defined:
  - Adds input port sub (1 bit), latched with the operands.
  - When sub=1: opB latched as ~b, and the initial carry = 1 (cin ignored).
  - ovf uses the inverted b MSB.
- SUB_EN undefined: no sub port; pure add with cin.

Decomposition:
- Shared package nsa_pkg holds:
  - enum typedef nsa_state_t {IDLE, RUN, DONE};
  - function nsa_ovf(a_msb, b_msb, s_msb).
- One sub-module: the existing CLA_4bit slice, instantiated once; PG/GG left unconnected.
- Counter width is $clog2(NIB+1), local to the block.

Test Plan (WIDTH=16):
- a=0x1234, b=0x0F0F, cin=0, out_ready=1 -> sum=0x2143, cout=0, ovf=0; out_valid exactly 4 cycles after accept, 1 cycle wide.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after DONE, with in_valid=1 and a=0xAAAA presented -> out_valid, sum and in_ready=0 held stable; 0xAAAA not accepted until IDLE.
- Reset pulse during RUN cycle 2 of a=0x1111, b=0x2222 -> immediately in_ready=1, out_valid=0, sum=0; next op a=0x0003, b=0x0004 gives sum=0x0007.
- SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
